// File: rtl/axi_lite_pkg.sv
// Shared constants and FSM state types for the AXI-Lite register slave.
// Response codes, register offsets and the write/read state encodings live here.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [3:0] REG0_OFFSET = 4'h0;
    localparam logic [3:0] REG1_OFFSET = 4'h4;
    localparam logic [3:0] REG2_OFFSET = 4'h8;
    localparam logic [3:0] WCNT_OFFSET = 4'hC;

    localparam logic [1:0] WCNT_INDEX  = WCNT_OFFSET[3:2];

    typedef enum logic [1:0] {
        W_IDLE,
        W_HAVE_A,
        W_HAVE_D,
        W_RESP
    } w_state_t;

    typedef enum logic {
        R_IDLE,
        R_RESP
    } r_state_t;

    // Word index into the 4-entry map; the two byte-lane bits are dropped.
    function automatic logic [1:0] reg_index(input logic [3:0] addr);
        return addr[3:2];
    endfunction

endpackage

// File: rtl/axi_lite_reg_slave_if.sv
// AXI-Lite bus bundle for the register slave; master drives requests, slave drives
// ready/response channels.
interface axi_lite_reg_slave_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] AWADDR;
    logic                  AWVALID;
    logic                  AWREADY;
    logic [DATA_WIDTH-1:0] WDATA;
    logic                  WVALID;
    logic                  WREADY;
    logic [1:0]            BRESP;
    logic                  BVALID;
    logic                  BREADY;
    logic [ADDR_WIDTH-1:0] ARADDR;
    logic                  ARVALID;
    logic                  ARREADY;
    logic [DATA_WIDTH-1:0] RDATA;
    logic [1:0]            RRESP;
    logic                  RVALID;
    logic                  RREADY;

    modport master (
        output AWADDR, AWVALID, WDATA, WVALID, BREADY, ARADDR, ARVALID, RREADY,
        input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );

    modport slave (
        input  AWADDR, AWVALID, WDATA, WVALID, BREADY, ARADDR, ARVALID, RREADY,
        output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );
endinterface

// File: rtl/axi_lite_reg_slave.sv
// AXI-Lite slave with three RW registers and a read-only completed-write counter.
// Define AXIL_SLVERR_EN to return SLVERR for WCNT writes and unaligned accesses.
import axi_lite_pkg::*;

module axi_lite_reg_slave #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                 ACLK,
    input  logic                 ARESET,
    axi_lite_reg_slave_if.slave  s_axil
);

    w_state_t              r_wstate;
    w_state_t              w_wstate_next;
    r_state_t              r_rstate;
    r_state_t              w_rstate_next;

    logic [ADDR_WIDTH-1:0] r_awaddr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [1:0]            r_bresp;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [1:0]            r_rresp;

    logic [DATA_WIDTH-1:0] r_regs [3];
    logic [DATA_WIDTH-1:0] r_wcnt;

    logic                  w_awready;
    logic                  w_wready;
    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic                  w_ar_hs;
    logic                  w_commit;
    logic [ADDR_WIDTH-1:0] w_wr_addr;
    logic [DATA_WIDTH-1:0] w_wr_data;
    logic [1:0]            w_wr_idx;
    logic [1:0]            w_rd_idx;
    logic                  w_wr_err;
    logic                  w_rd_err;
    logic                  w_commit_ok;
    logic [2:0]            w_reg_we;
    logic [DATA_WIDTH-1:0] w_rd_mux;

    assign w_awready = (r_wstate == W_IDLE) || (r_wstate == W_HAVE_D);
    assign w_wready  = (r_wstate == W_IDLE) || (r_wstate == W_HAVE_A);
    assign w_aw_hs   = s_axil.AWVALID && w_awready;
    assign w_w_hs    = s_axil.WVALID && w_wready;
    assign w_ar_hs   = s_axil.ARVALID && (r_rstate == R_IDLE);

    assign s_axil.AWREADY = w_awready;
    assign s_axil.WREADY  = w_wready;
    assign s_axil.BVALID  = (r_wstate == W_RESP);
    assign s_axil.BRESP   = r_bresp;
    assign s_axil.ARREADY = (r_rstate == R_IDLE);
    assign s_axil.RVALID  = (r_rstate == R_RESP);
    assign s_axil.RDATA   = r_rdata;
    assign s_axil.RRESP   = r_rresp;

    // Commit address/data come from the live bus or from whichever half was latched earlier.
    always_comb begin
        w_wstate_next = r_wstate;
        w_commit      = 1'b0;
        w_wr_addr     = s_axil.AWADDR;
        w_wr_data     = s_axil.WDATA;
        case (r_wstate)
            W_IDLE: begin
                if (w_aw_hs && w_w_hs) begin
                    w_commit      = 1'b1;
                    w_wstate_next = W_RESP;
                end else if (w_aw_hs) begin
                    w_wstate_next = W_HAVE_A;
                end else if (w_w_hs) begin
                    w_wstate_next = W_HAVE_D;
                end
            end
            W_HAVE_A: begin
                w_wr_addr = r_awaddr;
                if (w_w_hs) begin
                    w_commit      = 1'b1;
                    w_wstate_next = W_RESP;
                end
            end
            W_HAVE_D: begin
                w_wr_data = r_wdata;
                if (w_aw_hs) begin
                    w_commit      = 1'b1;
                    w_wstate_next = W_RESP;
                end
            end
            W_RESP: begin
                if (s_axil.BREADY) begin
                    w_wstate_next = W_IDLE;
                end
            end
            default: w_wstate_next = W_IDLE;
        endcase
    end

    assign w_wr_idx = reg_index(w_wr_addr[3:0]);
    assign w_rd_idx = reg_index(s_axil.ARADDR[3:0]);

`ifdef AXIL_SLVERR_EN
    assign w_wr_err = (w_wr_addr[1:0] != 2'b00) || (w_wr_idx == WCNT_INDEX);
    assign w_rd_err = (s_axil.ARADDR[1:0] != 2'b00);
`else
    logic w_unused_lsbs;
    assign w_unused_lsbs = ^{w_wr_addr[1:0], s_axil.ARADDR[1:0]};
    assign w_wr_err = 1'b0;
    assign w_rd_err = 1'b0;
`endif

    // WCNT is never a write target, so a WCNT write commits nothing in either build.
    assign w_commit_ok = w_commit && !w_wr_err && (w_wr_idx != WCNT_INDEX);

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_we
            assign w_reg_we[gi] = w_commit_ok && (w_wr_idx == 2'(gi));
        end
    endgenerate

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_wstate <= W_IDLE;
            r_awaddr <= '0;
            r_wdata  <= '0;
            r_bresp  <= RESP_OKAY;
        end else begin
            r_wstate <= w_wstate_next;
            if (w_aw_hs) r_awaddr <= s_axil.AWADDR;
            if (w_w_hs)  r_wdata  <= s_axil.WDATA;
            if (w_commit) r_bresp <= w_wr_err ? RESP_SLVERR : RESP_OKAY;
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            for (int i = 0; i < 3; i++) r_regs[i] <= '0;
            r_wcnt <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (w_reg_we[i]) r_regs[i] <= w_wr_data;
            end
            if (|w_reg_we) r_wcnt <= r_wcnt + 1'b1;
        end
    end

    always_comb begin
        w_rd_mux = r_wcnt;
        case (w_rd_idx)
            2'd0:    w_rd_mux = r_regs[0];
            2'd1:    w_rd_mux = r_regs[1];
            2'd2:    w_rd_mux = r_regs[2];
            default: w_rd_mux = r_wcnt;
        endcase
    end

    always_comb begin
        w_rstate_next = r_rstate;
        case (r_rstate)
            R_IDLE:  if (w_ar_hs) w_rstate_next = R_RESP;
            R_RESP:  if (s_axil.RREADY) w_rstate_next = R_IDLE;
            default: w_rstate_next = R_IDLE;
        endcase
    end

    // Read data is captured from pre-edge register contents, so a same-edge write is not visible.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_rstate <= R_IDLE;
            r_rdata  <= '0;
            r_rresp  <= RESP_OKAY;
        end else begin
            r_rstate <= w_rstate_next;
            if (w_ar_hs) begin
                r_rdata <= w_rd_err ? '0 : w_rd_mux;
                r_rresp <= w_rd_err ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

endmodule
